mux_nto1_pipe: RTL and testbench
================================

MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel, legal range 1..64.
REQ-002 Parameter CHANNELS, default 16: number of input channels, legal range 2..64.
REQ-003 Derived SEL_W = clog2(CHANNELS); not user-overridable.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel valid.
REQ-008 in_ready  output  CHANNELS  per-channel ready; combinational, at most one bit high.
REQ-009 sel  input  SEL_W  channel select, used in direct mode only.
REQ-010 mode  input  1  0 = direct select, 1 = round-robin scan.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  output register holds data.
REQ-014 out_ready  input  1  downstream accepts out_data.

Function
REQ-015 The output register has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en = !out_valid | out_ready; a transfer on channel k occurs when in_valid[k] & in_ready[k].
REQ-017 Direct mode: in_ready[sel] = load_en; all other in_ready bits are 0.
REQ-018 Direct mode with sel >= CHANNELS: all in_ready bits are 0; no transfer occurs.
REQ-019 Scan mode: grant goes to the first channel with in_valid=1, searching upward from pointer ptr and wrapping from CHANNELS-1 to 0; in_ready[grant] = load_en.
REQ-020 Scan mode, after a transfer on channel g: ptr <= g+1, wrapping CHANNELS-1 to 0; with no transfer, ptr holds.
REQ-021 While mode=0, ptr is cleared to 0 every cycle.
REQ-022 On transfer: out_data <= channel data, out_chan <= channel index, out_valid <= 1; latency is exactly one cycle.
REQ-023 FULL with out_ready=1 and no transfer: out_valid <= 0.
REQ-024 FULL with out_ready=1 and a simultaneous transfer: new data is loaded with no bubble, giving full throughput of one word per cycle.
REQ-025 FULL with out_ready=0: out_data, out_chan and out_valid hold; all in_ready bits are 0.
REQ-026 A change on mode or sel takes effect in the same cycle combinationally; the word already held in the output register is unaffected.
REQ-027 in_data and in_valid values on non-granted channels have no effect.

Reset
REQ-028 rst_n low asynchronously forces out_valid=0, out_data=0, out_chan=0 and ptr=0.
REQ-029 While rst_n is low, all in_ready bits are 0.
REQ-030 Assertion of rst_n while FULL discards the held word, with no transfer reported.
REQ-031 Deassertion is followed by normal operation starting on the next rising edge.

Configuration
REQ-032 Macro MUX_PARITY_EN defined: add output out_parity (1 bit), registered with out_data, equal to the XOR of the loaded word (even parity); its reset value is 0 and it holds whenever out_data holds.
REQ-033 Macro MUX_PARITY_EN undefined: the out_parity port and its logic are absent; all other behaviour is identical.

Verification
REQ-034 Reset: hold rst_n=0 with in_valid all 1 -> out_valid=0, out_data=0, in_ready=0; first word appears one cycle after release.
REQ-035 Direct, CHANNELS=16, WIDTH=8: sel=5, in_valid[5]=1, ch5=0xA5, out_ready=1 -> next cycle out_data=0xA5, out_chan=5, out_valid=1; sel=3 next cycle with ch3=0x3C gives back-to-back output.
REQ-036 Backpressure: FULL with 0x11, out_ready=0 for 3 cycles while in_valid[sel]=1 -> out_data stays 0x11 and in_ready=0; out_ready=1 -> next word is loaded the same cycle.
REQ-037 Scan: in_valid set on channels 2, 7 and 15, out_ready=1 -> out_chan sequence 2, 7, 15, 2; ptr wraps 15 -> 0.
REQ-038 Out-of-range select: CHANNELS=12, sel=13 -> in_ready=0 and out_valid falls to 0 once drained.
REQ-039 MUX_PARITY_EN defined: words 0x07 then 0x03 -> out_parity 1 then 0; rst_n pulse mid-stream -> out_valid=0 and out_parity=0 asynchronously.

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// N-to-1 channel multiplexer with direct or round-robin selection and a one-deep registered output stage.
// Define MUX_PARITY_EN to add the even-parity output out_parity.
module mux_nto1_pipe #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_PARITY_EN
  ,
  output logic                      out_parity
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [SEL_W:0]   CH_X = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [SEL_W-1:0]  ptr_r;
  logic [WIDTH-1:0]  data_r;
  logic [SEL_W-1:0]  chan_r;
  logic [SEL_W-1:0]  scan_grant_s;
  logic              scan_hit_s;
  logic [SEL_W-1:0]  grant_s;
  logic              grant_vld_s;
  logic              load_en_s;
  logic              xfer_s;
  logic [WIDTH-1:0]  ch_data_s [CHANNELS];

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                 input logic [SEL_W:0]   off);
    logic [SEL_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= CH_X) begin
      sum = sum - CH_X;
    end else begin
      sum = sum;
    end
    return sum[SEL_W-1:0];
  endfunction

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return (idx == LAST) ? {SEL_W{1'b0}} : idx + SEL_W'(1);
  endfunction

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch_data_s[k] = in_data[k*WIDTH +: WIDTH];
  end

  // Round-robin search: first valid channel at or above ptr_r, wrapping past the last channel.
  always_comb begin
    scan_hit_s   = 1'b0;
    scan_grant_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!scan_hit_s && in_valid[wrap_add(ptr_r, (SEL_W+1)'(i))]) begin
        scan_hit_s   = 1'b1;
        scan_grant_s = wrap_add(ptr_r, (SEL_W+1)'(i));
      end else begin
        scan_hit_s   = scan_hit_s;
      end
    end
  end

  // Grant selection; an out-of-range direct select grants nobody.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    if (mode) begin
      grant_s     = scan_grant_s;
      grant_vld_s = scan_hit_s;
    end else if ({1'b0, sel} < CH_X) begin
      grant_s     = sel;
      grant_vld_s = 1'b1;
    end else begin
      grant_s     = '0;
      grant_vld_s = 1'b0;
    end
  end

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output-stage next state: a transfer always fills, a drain without refill empties.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (xfer_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (xfer_s) begin
          state_nxt_s = FULL;
        end else if (out_ready) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Handshake outputs; ready is suppressed while reset is asserted.
  always_comb begin
    in_ready  = '0;
    load_en_s = (state_r == EMPTY) | out_ready;
    xfer_s    = 1'b0;
    if (rst_n && grant_vld_s && load_en_s) begin
      in_ready[grant_s] = 1'b1;
      xfer_s            = in_valid[grant_s];
    end else begin
      in_ready = '0;
      xfer_s   = 1'b0;
    end
  end

  // Scan pointer: advances past the served channel, parked at zero in direct mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (!mode) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      ptr_r <= next_idx(grant_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Output data and channel index, loaded only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      chan_r <= '0;
    end else if (xfer_s) begin
      data_r <= ch_data_s[grant_s];
      chan_r <= grant_s;
    end else begin
      data_r <= data_r;
      chan_r <= chan_r;
    end
  end

  assign out_data  = data_r;
  assign out_chan  = chan_r;
  assign out_valid = (state_r == FULL);

`ifdef MUX_PARITY_EN
  logic parity_r;

  // Even parity of the word, tracking the data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if (xfer_s) begin
      parity_r <= even_parity(ch_data_s[grant_s]);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign out_parity = parity_r;
`else
  logic unused_parity_s;
  assign unused_parity_s = even_parity(data_r);
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: scoreboard queue filled by stimulus, drained by an output monitor.
module tb_mux_nto1_pipe;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] chan;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_data;
  logic [15:0]  in_valid;
  logic [15:0]  in_ready;
  logic [3:0]   sel;
  logic         mode;
  logic [7:0]   out_data;
  logic [3:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  d12_in_data;
  logic [11:0]  d12_in_valid;
  logic [11:0]  d12_in_ready;
  logic [3:0]   d12_sel;
  logic [7:0]   d12_out_data;
  logic [3:0]   d12_out_chan;
  logic         d12_out_valid;

`ifdef MUX_PARITY_EN
  logic         out_parity;
  logic         d12_out_parity;
`endif

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mux_nto1_pipe #(.WIDTH(8), .CHANNELS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  mux_nto1_pipe #(.WIDTH(8), .CHANNELS(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_data(d12_in_data), .in_valid(d12_in_valid),
    .in_ready(d12_in_ready), .sel(d12_sel), .mode(1'b0), .out_data(d12_out_data),
    .out_chan(d12_out_chan), .out_valid(d12_out_valid), .out_ready(1'b1)
`ifdef MUX_PARITY_EN
    , .out_parity(d12_out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    in_data[k*8 +: 8] = v;
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got data %0h chan %0d, expected no word", out_data, out_chan);
      end else begin
        e = sb_q.pop_front();
        if (out_data !== e.data || out_chan !== e.chan) begin
          n_err++;
          $display("FAIL sb_word: got data %0h chan %0d, expected data %0h chan %0d",
                   out_data, out_chan, e.data, e.chan);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    in_data      = '0;
    in_valid     = 16'hFFFF;
    sel          = 4'd5;
    mode         = 1'b0;
    out_ready    = 1'b1;
    d12_in_data  = '0;
    d12_in_valid = 12'hFFF;
    d12_sel      = 4'd13;
    set_ch(5, 8'hA5);
    repeat (3) step();

    // reset state with all inputs valid
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'h0);
    check("rst_out_chan",  64'(out_chan),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'h0);

    rst_n = 1'b1;
    #1;
    check("dir_ready_sel5", 64'(in_ready), 64'h0020);
    check("oor_ready_sel13", 64'(d12_in_ready), 64'h000);
    sb_q.push_back('{data: 8'hA5, chan: 4'd5});
    step();
    check("first_word_valid", 64'(out_valid), 64'd1);

    // back-to-back direct select
    sel = 4'd3; in_valid = 16'h0008; set_ch(3, 8'h3C);
    sb_q.push_back('{data: 8'h3C, chan: 4'd3});
    step();
    sel = 4'd1; in_valid = 16'h0002; set_ch(1, 8'h11);
    sb_q.push_back('{data: 8'h11, chan: 4'd1});
    step();

    // backpressure holds the word and blocks every channel
    out_ready = 1'b0; set_ch(1, 8'h22);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_data_hold", 64'(out_data),  64'h11);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'h0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'h0002);
    sb_q.push_back('{data: 8'h22, chan: 4'd1});
    step();
    check("bp_next_word", 64'(out_data), 64'h22);
    in_valid = 16'h0000;
    step();
    check("drain_valid", 64'(out_valid), 64'd0);

    // round-robin over channels 2, 7, 15 with wrap
    mode = 1'b1; in_valid = 16'h8084;
    set_ch(2, 8'h2A); set_ch(7, 8'h7B); set_ch(15, 8'hFC);
    #1;
    check("scan_ready_2", 64'(in_ready), 64'h0004);
    sb_q.push_back('{data: 8'h2A, chan: 4'd2});
    sb_q.push_back('{data: 8'h7B, chan: 4'd7});
    sb_q.push_back('{data: 8'hFC, chan: 4'd15});
    sb_q.push_back('{data: 8'h2A, chan: 4'd2});
    step();
    check("scan_ready_7", 64'(in_ready), 64'h0080);
    step();
    check("scan_ready_15", 64'(in_ready), 64'h8000);
    step();
    check("scan_ready_wrap", 64'(in_ready), 64'h0004);
    step();
    check("scan_last_chan", 64'(out_chan), 64'd2);
    in_valid = 16'h0000; mode = 1'b0;
    step();
    check("scan_drain_valid", 64'(out_valid), 64'd0);

    // out-of-range select on the 12-channel instance
    d12_sel = 4'd4; d12_in_data[4*8 +: 8] = 8'h44;
    #1;
    check("oor_ready_sel4", 64'(d12_in_ready), 64'h010);
    step();
    check("oor_load_valid", 64'(d12_out_valid), 64'd1);
    check("oor_load_data",  64'(d12_out_data),  64'h44);
    check("oor_load_chan",  64'(d12_out_chan),  64'd4);
    d12_sel = 4'd13;
    #1;
    check("oor_ready_zero", 64'(d12_in_ready), 64'h000);
    step();
    check("oor_drained", 64'(d12_out_valid), 64'd0);

    // parity words and asynchronous reset mid-stream
    sel = 4'd0; in_valid = 16'h0001; set_ch(0, 8'h07);
    sb_q.push_back('{data: 8'h07, chan: 4'd0});
    step();
    check("par_word1", 64'(out_data), 64'h07);
`ifdef MUX_PARITY_EN
    check("par_bit1", 64'(out_parity), 64'd1);
`endif
    set_ch(0, 8'h03);
    step();
    out_ready = 1'b0; in_valid = 16'h0000;
    check("par_word2", 64'(out_data), 64'h03);
    check("par_chan2", 64'(out_chan), 64'd0);
`ifdef MUX_PARITY_EN
    check("par_bit2", 64'(out_parity), 64'd0);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data",  64'(out_data),  64'h0);
    check("arst_ready", 64'(in_ready),  64'h0);
`ifdef MUX_PARITY_EN
    check("arst_parity", 64'(out_parity), 64'd0);
`endif
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
